// File: rtl/idc_ramp_if.sv
// Request/status bundle between bias/config logic and idc_ramp_ctrl.
// Latency: none; this file only carries wires.
// Backpressure: req_valid/req_ready handshake. The controller drops req_ready outside IDLE.
//
// Signals:
//   en         master->slave  0 ramps the output to 0 (shutdown)
//   req_valid  master->slave  target code offered
//   req_code   master->slave  target code (N bits, unsigned)
//   req_ready  slave->master  controller can accept a target
//   cur_code   slave->master  code currently applied
//   busy       slave->master  controller not idle
//   done       slave->master  1-cycle pulse: target reached and settled
//   abort      slave->master  1-cycle pulse: shutdown ramp reached 0
//   refnode    master->slave  reference node (carried, never read)
//   outnode    slave->master  output current as a PWL sample
//
// A PWL sample is a fixed-point pair:
//   val_fa       value at the last write, in femtoamps (signed)
//   slope_fa_ns  slope from that write onwards, in femtoamps per nanosecond (signed)
// The value at a time t after the write is val_fa + slope_fa_ns * t[ns].
interface idc_ramp_if #(
   parameter int N = 8
);
   typedef struct packed {
      logic signed [63:0] val_fa;
      logic signed [63:0] slope_fa_ns;
   } pwl_t;

   logic         en;
   logic         req_valid;
   logic [N-1:0] req_code;
   logic         req_ready;
   logic [N-1:0] cur_code;
   logic         busy;
   logic         done;
   logic         abort;
   pwl_t         refnode;
   pwl_t         outnode;

   modport master (
      output en, req_valid, req_code, refnode,
      input  req_ready, cur_code, busy, done, abort, outnode
   );

   modport slave (
      input  en, req_valid, req_code, refnode,
      output req_ready, cur_code, busy, done, abort, outnode
   );
endinterface

// File: rtl/idc_ramp_ctrl.sv
// Soft-start sequencer for a DC bias current source: slews cur_code toward a target in bounded steps.
// Latency: first step lands STEP_DIV cycles after acceptance, one step every STEP_DIV cycles after that.
// Backpressure: req_ready only in IDLE with en high; offers while busy are dropped, nothing is queued.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   idc_ramp_if.slave: en, req_valid/req_code/req_ready, cur_code, busy, done, abort,
//         refnode (unused), outnode (value = sign*cur_code*LSB, sign = +1 source, -1 sink)
//
// Build option IDC_SLEW_PWL_EN:
//   undefined: outnode is a staircase; each write carries the new value with slope 0.
//   defined:   each step writes the old value plus a slope that reaches the new value at the
//              next step edge; the slope of the final step is cleared STEP_DIV cycles later.
//   Digital ports and their timing are identical in both builds.
module idc_ramp_ctrl #(
   parameter int  N          = 8,
   parameter real LSB        = 1.0e-6,
   parameter int  is_n       = 1,
   parameter int  STEP       = 4,
   parameter int  STEP_DIV   = 2,
   parameter int  SETTLE_CYC = 3,
   parameter real TCLK       = 1.0e-9
) (
   input  logic      clk,
   input  logic      rst,
   idc_ramp_if.slave bus
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
   // SETTLE_CYC of 0 and 1 both leave SETTLE after a single cycle
   localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [N:0]       STEP_MAX = (N+1)'(STEP);

   // output current per code, in femtoamps
   localparam longint LSB_FA = longint'(LSB * 1.0e15);

`ifdef IDC_SLEW_PWL_EN
   // slope per code of step, spread over one step period: fA per ns
   localparam longint SLOPE_FA_NS = longint'((LSB * 1.0e15) / (real'(STEP_DIV) * TCLK * 1.0e9));
`else
   localparam real unused_tclk = TCLK;
`endif

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RAMP   = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;

   logic [1:0]         state;
   logic [N-1:0]       cur;
   logic [N-1:0]       target;
   logic [DIV_W-1:0]   div_cnt;
   logic [SET_W-1:0]   settle_cnt;
   logic               shut;        // current ramp is a shutdown toward 0
   logic               done_q;
   logic               abort_q;
   logic signed [63:0] out_val;
   logic signed [63:0] out_slope;

`ifdef IDC_SLEW_PWL_EN
   logic               hold_pend;   // final segment still sloping, clear it later
   logic [DIV_W-1:0]   hold_cnt;
`endif

   // ------------------------------------------------------------------
   // Step arithmetic in N+1 bits so the distance never wraps; the step is
   // clamped to the distance, so cur_step always lies between cur and target.
   // ------------------------------------------------------------------
   logic [N:0]   cur_x;
   logic [N:0]   tgt_x;
   logic [N:0]   diff;
   logic [N:0]   step_amt;
   logic [N:0]   cur_step;
   logic         up;
   logic         div_wrap;
   logic [N-1:0] next_cur;
   logic [N-1:0] step_cur;
   logic         reach;
   logic         shut_go;
   logic         step_go;

   always_comb begin
      cur_x    = {1'b0, cur};
      tgt_x    = {1'b0, target};
      up       = tgt_x > cur_x;
      diff     = up ? (tgt_x - cur_x) : (cur_x - tgt_x);
      step_amt = (diff < STEP_MAX) ? diff : STEP_MAX;
      cur_step = up ? (cur_x + step_amt) : (cur_x - step_amt);
      next_cur = cur_step[N-1:0];
      div_wrap = (div_cnt == DIV_LAST);
      // code that RAMP would hold after this edge
      step_cur = div_wrap ? next_cur : cur;
      reach    = (step_cur == target);
      // en low starts one shutdown; a ramp already heading to 0 is left alone.
      // In IDLE shut is always clear, so only a non-zero output needs ramping.
      shut_go  = !bus.en && !shut && ((state != S_IDLE) || (cur != '0));
      step_go  = (state == S_RAMP) && !shut_go && div_wrap && (next_cur != cur);
   end

   function automatic logic signed [63:0] code_to_fa(input logic [N-1:0] c);
      logic signed [63:0] mag;
      mag = $signed(64'(c)) * LSB_FA;
      return (is_n != 0) ? mag : -mag;
   endfunction

`ifdef IDC_SLEW_PWL_EN
   logic signed [63:0] slope_mag;
   logic signed [63:0] step_slope;

   always_comb begin
      slope_mag  = $signed(64'(step_amt)) * SLOPE_FA_NS;
      // positive when a source ramps up or a sink ramps down
      step_slope = (up == (is_n != 0)) ? slope_mag : -slope_mag;
   end
`endif

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cur        <= '0;
         target     <= '0;
         div_cnt    <= '0;
         settle_cnt <= '0;
         shut       <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         if (shut_go) begin
            // retarget to 0; div_cnt keeps its phase
            target <= '0;
            shut   <= 1'b1;
            state  <= S_RAMP;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.en && bus.req_valid) begin
                     target <= bus.req_code;
                     if (bus.req_code == cur) begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                     end else begin
                        state   <= S_RAMP;
                        div_cnt <= '0;
                     end
                  end
               end
               S_RAMP: begin
                  div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                  if (div_wrap) begin
                     cur <= next_cur;
                  end
                  if (reach) begin
                     if (shut) begin
                        state   <= S_IDLE;
                        shut    <= 1'b0;
                        abort_q <= 1'b1;
                     end else begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                     end
                  end
               end
               S_SETTLE: begin
                  if (settle_cnt == SET_LAST) begin
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt + SET_W'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Output current: written only when cur_code changes (and on reset)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_val   <= '0;
         out_slope <= '0;
`ifdef IDC_SLEW_PWL_EN
         hold_pend <= 1'b0;
         hold_cnt  <= '0;
`endif
      end else if (step_go) begin
`ifdef IDC_SLEW_PWL_EN
         // segment starts at the old value and lands on the new one a step period later
         out_val   <= code_to_fa(cur);
         out_slope <= step_slope;
         hold_pend <= reach;
         hold_cnt  <= '0;
`else
         out_val   <= code_to_fa(next_cur);
         out_slope <= '0;
`endif
      end
`ifdef IDC_SLEW_PWL_EN
      else if (hold_pend) begin
         if (hold_cnt == DIV_LAST) begin
            out_val   <= code_to_fa(cur);
            out_slope <= '0;
            hold_pend <= 1'b0;
         end else begin
            hold_cnt <= hold_cnt + DIV_W'(1);
         end
      end
`endif
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.req_ready = (state == S_IDLE) && bus.en && !rst;
   assign bus.cur_code  = cur;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;
   assign bus.abort     = abort_q;
   assign bus.outnode   = {out_val, out_slope};

   // refnode is carried only for port compatibility; cur_step's top bit is always 0
   logic unused_bits;
   assign unused_bits = ^{bus.refnode, cur_step[N]};

endmodule

// File: tb/tb_idc_ramp_ctrl.sv
`timescale 1ns/10ps
module tb_idc_ramp_ctrl;

   localparam int     N      = 8;
   localparam longint LSB_FA = 64'sd1000000000;   // 1e-6 A in femtoamps

   logic clk = 1'b0;
   logic rst;
   always #0.5 clk = ~clk;                       // 1 ns period, matches TCLK

   idc_ramp_if #(.N(N)) bus ();
   idc_ramp_if #(.N(N)) bus_n ();

   idc_ramp_ctrl #(
      .N(N), .LSB(1.0e-6), .is_n(1), .STEP(4), .STEP_DIV(2), .SETTLE_CYC(3), .TCLK(1.0e-9)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   // sink-polarity copy driven with identical stimulus
   idc_ramp_ctrl #(
      .N(N), .LSB(1.0e-6), .is_n(0), .STEP(4), .STEP_DIV(2), .SETTLE_CYC(3), .TCLK(1.0e-9)
   ) dut_n (
      .clk(clk), .rst(rst), .bus(bus_n.slave)
   );

   assign bus.refnode     = '0;
   assign bus_n.refnode   = '0;
   assign bus_n.en        = bus.en;
   assign bus_n.req_valid = bus.req_valid;
   assign bus_n.req_code  = bus.req_code;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic v, input logic [7:0] c);
      rst           = r;
      bus.en        = e;
      bus.req_valid = v;
      bus.req_code  = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #0.1;
   endtask

   typedef struct {
      logic       rst, en, vld;
      logic [7:0] code;
      logic [7:0] cur;
      logic       busy, done, abort, rdy;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [7:0] c,
                               input logic [7:0] cur, input logic b, input logic d,
                               input logic a, input logic rd);
      vec_t t;
      t.rst = r; t.en = e; t.vld = v; t.code = c;
      t.cur = cur; t.busy = b; t.done = d; t.abort = a; t.rdy = rd;
      return t;
   endfunction

   vec_t vt[29];

   // shutdown sequence expectations, one entry per cycle after cur reaches 8
   logic       sd_en   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [7:0] sd_cur  [6] = '{8'd8, 8'd8, 8'd4, 8'd4, 8'd0, 8'd0};
   logic       sd_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic       sd_abort[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic       sd_rdy  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      //            rst en vld code   cur busy done abort rdy
      vt[0]  = mk(1, 1, 0, 8'd0,   8'd0,  0, 0, 0, 0);   // reset
      vt[1]  = mk(1, 1, 0, 8'd0,   8'd0,  0, 0, 0, 0);
      vt[2]  = mk(0, 1, 0, 8'd0,   8'd0,  0, 0, 0, 1);   // ready after rst drops
      vt[3]  = mk(0, 1, 1, 8'd10,  8'd0,  1, 0, 0, 0);   // accept 10
      vt[4]  = mk(0, 1, 0, 8'd0,   8'd0,  1, 0, 0, 0);
      vt[5]  = mk(0, 1, 0, 8'd0,   8'd4,  1, 0, 0, 0);   // +2
      vt[6]  = mk(0, 1, 0, 8'd0,   8'd4,  1, 0, 0, 0);
      vt[7]  = mk(0, 1, 0, 8'd0,   8'd8,  1, 0, 0, 0);   // +4
      vt[8]  = mk(0, 1, 0, 8'd0,   8'd8,  1, 0, 0, 0);
      vt[9]  = mk(0, 1, 0, 8'd0,   8'd10, 1, 0, 0, 0);   // +6, clamped, SETTLE
      vt[10] = mk(0, 1, 0, 8'd0,   8'd10, 1, 0, 0, 0);
      vt[11] = mk(0, 1, 0, 8'd0,   8'd10, 1, 0, 0, 0);
      vt[12] = mk(0, 1, 0, 8'd0,   8'd10, 0, 1, 0, 1);   // done
      vt[13] = mk(0, 1, 0, 8'd0,   8'd10, 0, 0, 0, 1);
      vt[14] = mk(0, 1, 1, 8'd1,   8'd10, 1, 0, 0, 0);   // accept 1
      vt[15] = mk(0, 1, 1, 8'd50,  8'd10, 1, 0, 0, 0);   // offers while busy ignored
      vt[16] = mk(0, 1, 1, 8'd50,  8'd6,  1, 0, 0, 0);
      vt[17] = mk(0, 1, 1, 8'd50,  8'd6,  1, 0, 0, 0);
      vt[18] = mk(0, 1, 1, 8'd50,  8'd2,  1, 0, 0, 0);
      vt[19] = mk(0, 1, 1, 8'd50,  8'd2,  1, 0, 0, 0);
      vt[20] = mk(0, 1, 1, 8'd50,  8'd1,  1, 0, 0, 0);   // no undershoot
      vt[21] = mk(0, 1, 1, 8'd50,  8'd1,  1, 0, 0, 0);
      vt[22] = mk(0, 1, 1, 8'd50,  8'd1,  1, 0, 0, 0);
      vt[23] = mk(0, 1, 0, 8'd0,   8'd1,  0, 1, 0, 1);   // done
      vt[24] = mk(0, 1, 1, 8'd1,   8'd1,  1, 0, 0, 0);   // same target: SETTLE directly
      vt[25] = mk(0, 1, 0, 8'd0,   8'd1,  1, 0, 0, 0);
      vt[26] = mk(0, 1, 0, 8'd0,   8'd1,  1, 0, 0, 0);
      vt[27] = mk(0, 1, 0, 8'd0,   8'd1,  0, 1, 0, 1);   // done after 3 cycles
      vt[28] = mk(0, 1, 0, 8'd0,   8'd1,  0, 0, 0, 1);

      drive(1, 1, 0, 8'd0);
      for (int i = 0; i < 29; i++) begin
         drive(vt[i].rst, vt[i].en, vt[i].vld, vt[i].code);
         tick();
         chk($sformatf("vec%0d.cur", i),   longint'(bus.cur_code),  longint'(vt[i].cur));
         chk($sformatf("vec%0d.busy", i),  longint'(bus.busy),      longint'(vt[i].busy));
         chk($sformatf("vec%0d.done", i),  longint'(bus.done),      longint'(vt[i].done));
         chk($sformatf("vec%0d.abort", i), longint'(bus.abort),     longint'(vt[i].abort));
         chk($sformatf("vec%0d.rdy", i),   longint'(bus.req_ready), longint'(vt[i].rdy));
`ifndef IDC_SLEW_PWL_EN
         chk($sformatf("vec%0d.out_src", i), bus.outnode.val_fa,   longint'(vt[i].cur) * LSB_FA);
         chk($sformatf("vec%0d.out_snk", i), bus_n.outnode.val_fa, -(longint'(vt[i].cur) * LSB_FA));
`endif
      end
`ifndef IDC_SLEW_PWL_EN
      chk("staircase.slope", bus.outnode.slope_fa_ns, 0);
`endif

      // shutdown from cur=8 during a ramp to 200; en comes back mid-ramp without effect
      drive(1, 1, 0, 8'd0);   tick();
      drive(0, 1, 0, 8'd0);   tick();
      drive(0, 1, 1, 8'd200); tick();
      drive(0, 1, 0, 8'd0);
      repeat (4) tick();
      chk("sd.start_cur", longint'(bus.cur_code), 8);
      for (int i = 0; i < 6; i++) begin
         drive(0, sd_en[i], 0, 8'd0);
         tick();
         chk($sformatf("sd%0d.cur", i),   longint'(bus.cur_code),  longint'(sd_cur[i]));
         chk($sformatf("sd%0d.busy", i),  longint'(bus.busy),      longint'(sd_busy[i]));
         chk($sformatf("sd%0d.abort", i), longint'(bus.abort),     longint'(sd_abort[i]));
         chk($sformatf("sd%0d.rdy", i),   longint'(bus.req_ready), longint'(sd_rdy[i]));
         chk($sformatf("sd%0d.done", i),  longint'(bus.done),      0);
      end

      // reset in the middle of a ramp
      drive(0, 1, 1, 8'd100); tick();
      drive(0, 1, 0, 8'd0);
      repeat (4) tick();
      chk("rst_mid.before", longint'(bus.cur_code), 8);
      drive(1, 1, 0, 8'd0); tick();
      chk("rst_mid.cur",   longint'(bus.cur_code),  0);
      chk("rst_mid.busy",  longint'(bus.busy),      0);
      chk("rst_mid.rdy",   longint'(bus.req_ready), 0);
      chk("rst_mid.out",   bus.outnode.val_fa,      0);
      chk("rst_mid.slope", bus.outnode.slope_fa_ns, 0);
      drive(0, 1, 0, 8'd0); tick();
      chk("rst_mid.rdy_after", longint'(bus.req_ready), 1);
      chk("rst_mid.cur_after", longint'(bus.cur_code),  0);

`ifdef IDC_SLEW_PWL_EN
      // 0 -> 4 in one step: 4e-6 A over 2 ns = 2e9 fA/ns; 2e9 fA at mid-step
      drive(0, 1, 1, 8'd4); tick();
      drive(0, 1, 0, 8'd0);
      repeat (2) tick();
      chk("pwl.cur",   longint'(bus.cur_code),  4);
      chk("pwl.start", bus.outnode.val_fa,      0);
      chk("pwl.slope", bus.outnode.slope_fa_ns, 64'sd2000000000);
      chk("pwl.mid",   bus.outnode.val_fa + bus.outnode.slope_fa_ns, 64'sd2000000000);
      repeat (2) tick();
      chk("pwl.final_val",   bus.outnode.val_fa,      4 * LSB_FA);
      chk("pwl.final_slope", bus.outnode.slope_fa_ns, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
      $fatal(1);
   end

endmodule
